// File: rtl/pm32.sv
// pm32 -- serial-parallel shift-add unsigned multiplier.
//
// One multiplier bit is consumed per clock, LSB first; the multiplicand is
// added in parallel into a 2*SIZE-bit accumulator. A start request captures
// the operands and (re)starts the operation from any state.
//
// Optional build macro:
//   PM32_EARLY_DONE_EN  finish as soon as the remaining multiplier bits are
//                       all zero (latency 2..SIZE+1 edges). When undefined,
//                       done always rises SIZE+1 edges after the start edge.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset
//   start  in   operation request (also aborts/restarts a busy operation)
//   mc     in   multiplicand, SIZE bits, unsigned
//   mp     in   multiplier, SIZE bits, unsigned
//   p      out  product register, 2*SIZE bits, unsigned
//   done   out  registered result-valid flag
module pm32 #(
  parameter int SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE-1:0]   mc,
  input  logic [SIZE-1:0]   mp,
  output logic [2*SIZE-1:0] p,
  output logic              done
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e            state_q;
  logic [2*SIZE-1:0] mcs_q;   // multiplicand, shifted left one place per bit
  logic [SIZE-1:0]   mp_q;    // multiplier, shifted right; bit 0 is current
  logic [CW-1:0]     cnt_q;   // index of the bit being processed
  logic [2*SIZE-1:0] p_q;
  logic              done_q;

  logic [2*SIZE-1:0] p_d;
  logic              last_d;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    p_d = p_q;
    if (mp_q[0]) begin
      p_d = p_q + mcs_q;
    end
  end

`ifdef PM32_EARLY_DONE_EN
  // Stop when this is the final bit position, or when every bit above the
  // one being processed now is zero (further adds would contribute nothing).
  always_comb begin
    last_d = (cnt_q == LAST_BIT) || ((mp_q >> 1) == '0);
  end
`else
  always_comb begin
    last_d = (cnt_q == LAST_BIT);
  end
`endif

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  // The operand registers and counter are reset too, so nothing stale from an
  // aborted operation can ever be observed after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mcs_q   <= '0;
      mp_q    <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else if (start) begin
      // Start wins in every state: capture, clear the result, (re)enter BUSY.
      state_q <= BUSY;
      mcs_q   <= {{SIZE{1'b0}}, mc};
      mp_q    <= mp;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        BUSY: begin
          p_q   <= p_d;
          mcs_q <= mcs_q << 1;
          mp_q  <= mp_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (last_d) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        IDLE, DONE: begin
          // Result and flag hold until the next start or reset.
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p    = p_q;
  assign done = done_q;

endmodule

// File: tb/tb_pm32.sv
// tb_pm32 -- directed testbench for pm32 (SIZE=32).
// Expected products are pushed to a scoreboard queue when an operation is
// started and popped when done rises. Expected latency follows the build:
// with PM32_EARLY_DONE_EN it depends on the multiplier's highest set bit.
module tb_pm32;

  localparam int SIZE = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [SIZE-1:0]   mc;
  logic [SIZE-1:0]   mp;
  logic [2*SIZE-1:0] p;
  logic              done;

  int total = 0;
  int bad   = 0;
  logic [2*SIZE-1:0] sb_q[$];

  always #5 clk = ~clk;

  pm32 #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mc    (mc),
    .mp    (mp),
    .p     (p),
    .done  (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Edges from the start-sampling edge (inclusive) until done reads 1.
  function automatic int exp_lat(input logic [SIZE-1:0] b);
`ifdef PM32_EARLY_DONE_EN
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (b[i]) return i + 2;
    end
    return 2;
`else
    return SIZE + 1;
`endif
  endfunction

  // Called at a negedge: one start pulse, then the operand inputs are
  // scrambled to prove they are not used after capture.
  task automatic start_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    mc    = a;
    mp    = b;
    start = 1'b1;
    sb_q.delete();
    sb_q.push_back(64'(a) * 64'(b));
    @(negedge clk);
    start = 1'b0;
    mc    = $urandom;
    mp    = $urandom;
  endtask

  // Called at the negedge right after the start edge; bounded wait for done.
  task automatic wait_done(input string tag, input int exp_l);
    int lat = 1;
    logic [63:0] exp_p;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_l));
    if (sb_q.size() > 0) begin
      exp_p = sb_q.pop_front();
      check({tag, " product"}, p, exp_p);
    end else begin
      check({tag, " scoreboard"}, 64'(sb_q.size()), 64'd1);
    end
  endtask

  initial begin
    logic [SIZE-1:0] a, b;
    logic seen_done;

    // Reset state, with start held high to show it is ignored under reset.
    rst   = 1'b0;
    start = 1'b0;
    mc    = '0;
    mp    = '0;
    #2;
    check("reset p", p, 64'd0);
    check("reset done", 64'(done), 64'd0);
    start = 1'b1;
    mc    = 32'd9;
    mp    = 32'd9;
    @(negedge clk);
    @(negedge clk);
    check("start under reset p", p, 64'd0);
    check("start under reset done", 64'(done), 64'd0);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);

    // 3 x 5, then hold for several cycles.
    start_op(32'd3, 32'd5);
    wait_done("3x5", exp_lat(32'd5));
    repeat (5) @(negedge clk);
    check("3x5 hold p", p, 64'd15);
    check("3x5 hold done", 64'(done), 64'd1);

    // Largest operands.
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("max", exp_lat(32'hFFFF_FFFF));
    check("max value", p, 64'hFFFF_FFFE_0000_0001);

    // Zero multiplier.
    start_op(32'h1234_5678, 32'd0);
    wait_done("zero mp", exp_lat(32'd0));

    // Start held for three edges with changing operands: last one wins.
    mc    = 32'd1;
    mp    = 32'd1;
    start = 1'b1;
    @(negedge clk);
    mc = 32'd2;
    mp = 32'd3;
    @(negedge clk);
    mc = 32'd11;
    mp = 32'd13;
    sb_q.delete();
    sb_q.push_back(64'd143);
    @(negedge clk);
    start = 1'b0;
    wait_done("held start", exp_lat(32'd13));

    // Restart mid-BUSY with 7 x 9.
    start_op(32'hDEAD_BEEF, 32'hFFFF_FFFF);
    repeat (9) @(negedge clk);
    check("pre-restart done", 64'(done), 64'd0);
    start_op(32'd7, 32'd9);
    wait_done("restart", exp_lat(32'd9));
    check("restart value", p, 64'd63);

    // Reset at the tenth BUSY edge: immediate clear, no later done.
    start_op(32'h0000_1234, 32'h8000_0001);
    repeat (9) @(negedge clk);
    check("pre-reset partial p", p, 64'h1234);
    rst = 1'b0;
    sb_q.delete();
    #1;
    check("busy reset p", p, 64'd0);
    check("busy reset done", 64'(done), 64'd0);
    start = 1'b1;
    mc    = 32'd5;
    mp    = 32'd5;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("no done after reset", 64'(seen_done), 64'd0);

    // Chained random operations with a reset pulse between each.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
      #2 rst = 1'b0;
      #1;
      check("chain reset done", 64'(done), 64'd0);
      #1 rst = 1'b1;
      @(negedge clk);
      start_op(a, b);
      wait_done("chain", exp_lat(b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
